// File: rtl/qam_pkg.sv
// Shared types for the QAM receive-side sample deserializer.
// Holds the default sample width, framer state enum and sample type.
package qam_pkg;

    localparam int SAMPLE_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } framer_state_e;

    typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/qam_sample_fifo.sv
// Synchronous show-ahead FIFO for reassembled samples.
// Ports: push/push_data in, push_ok (write taken), pop in,
// pop_data (head, 0 when empty), full, empty.
module qam_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ok,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;

    // Extra pointer bit tells full from empty when addresses match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop_ok = pop & ~empty;
    // A pop on the same edge frees the slot a full push needs.
    assign push_ok = push & (~full | pop_ok);

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/qam_sample_deserializer.sv
// Reassembles LSB-first serial samples framed by sof_in into a FIFO.
// Ports: clk, rst (async active-low), bit_in, sof_in, sample_out,
// sample_valid, sample_ready, overflow, resync_err, sample_count.
module qam_sample_deserializer
    import qam_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       sof_in,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic                       overflow,
    output logic                       resync_err,
    output logic [15:0]                sample_count
);

    localparam int IW = $clog2(SAMPLE_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(SAMPLE_W - 1);

    framer_state_e       state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic                overflow_q, overflow_d;
    logic                resync_q, resync_d;
    logic [15:0]         count_q, count_d;

    logic                push;
    logic                push_ok;
    logic                resync;
    logic [SAMPLE_W-1:0] push_word;
    logic [SAMPLE_W-1:0] head;
    logic                fifo_full;
    logic                fifo_empty;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        push      = 1'b0;
        resync    = 1'b0;
        // Last bit goes straight into the pushed word, not the register.
        push_word = shreg_q;
        push_word[SAMPLE_W-1] = bit_in;
        unique case (state_q)
            HUNT: begin
                if (sof_in) begin
                    shreg_d    = '0;
                    shreg_d[0] = bit_in;
                    idx_d      = IW'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (sof_in) begin
                    resync     = 1'b1;
                    shreg_d    = '0;
                    shreg_d[0] = bit_in;
                    idx_d      = IW'(1);
                end else if (idx_q == LAST_IDX) begin
                    push    = 1'b1;
                    shreg_d = '0;
                    idx_d   = '0;
                    state_d = HUNT;
                end else begin
                    shreg_d[idx_q] = bit_in;
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_comb begin
        overflow_d = overflow_q | (push & ~push_ok);
        resync_d   = resync_q | resync;
        count_d    = push_ok ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= HUNT;
            idx_q      <= '0;
            shreg_q    <= '0;
            overflow_q <= 1'b0;
            resync_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            overflow_q <= overflow_d;
            resync_q   <= resync_d;
            count_q    <= count_d;
        end
    end

    qam_sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_word),
        .push_ok   (push_ok),
        .pop       (sample_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign sample_out   = head;
    assign sample_valid = ~fifo_empty;
    assign overflow     = overflow_q;
    assign resync_err   = resync_q;
    assign sample_count = count_q;

endmodule
